// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch constants and fetch FSM encoding
package instr_fetch_unit_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {pc, inst} pairs with flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  assign dout = mem[rd];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: decoupled fetch stage; one outstanding memory request,
// prefetch FIFO toward decode, redirect flushes and drains in-flight fetches
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  fetch_state_t state, state_n;
  logic [XLEN-1:0] fpc, req_pc;
  logic full, empty, fire, push, pop;
  logic [2*XLEN-1:0] head;
  // a full FIFO blocks issue so every outstanding response has a free slot
  assign mem_req_valid = !rst && state == REQ && !full && !redirect_valid;
  assign mem_req_addr = fpc;
  assign fire = mem_req_valid && mem_req_ready;
  assign push = state == WAIT && mem_rsp_valid && !redirect_valid;
  assign inst_valid = !empty && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign {inst_pc, inst_data} = head;
  fetch_fifo #(
    .DEPTH(DEPTH),
    .W(2*XLEN),
    .RST_VAL({RESET_PC, {XLEN{1'b0}}})
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({req_pc, mem_rsp_data}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    state_n = state == REQ ? (fire ? WAIT : REQ) :
              mem_rsp_valid ? REQ :
              (state == WAIT && redirect_valid) ? DRAIN : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= REQ;
      fpc <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_n;
      if (redirect_valid) fpc <= redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      else if (fire) begin
        req_pc <= fpc;
        fpc <= fpc + XLEN'(4);
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random traffic against a queue-based fetch model
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} entry_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  logic clk = 0, rst = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] mem_req_addr, mem_rsp_data = 0;
  logic redirect_valid = 0, inst_valid, inst_ready = 0;
  logic [31:0] redirect_pc = 0, inst_data, inst_pc;
  int n_cmp = 0, n_bad = 0;
  entry_t q[$];
  mreq_t mq[$];
  logic [31:0] fpc, req_pc;
  bit inflight, drop, erv, eiv;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  initial begin
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 1000 == 0) begin
        rst = 1;
        redirect_valid = 0;
        mem_rsp_valid = 0;
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_pc", inst_pc, RESET_PC);
        check("rst_inst_data", inst_data, 0);
        q.delete();
        fpc = RESET_PC;
        inflight = 0;
        drop = 0;
        @(negedge clk);
        rst = 0;
      end
      redirect_valid = $urandom_range(99) < 8;
      redirect_pc = $urandom & 32'hFFF;
      inst_ready = (cyc % 64 < 16) ? 1'b0 : ($urandom_range(99) < 60);
      mem_req_ready = $urandom_range(99) < 70;
      mem_rsp_valid = mq.size() != 0 && mq[0].due <= cyc;
      mem_rsp_data = mem_rsp_valid ? mdata(mq[0].addr) : 32'h0;
      #1;
      erv = !inflight && !redirect_valid && q.size() < DEPTH;
      eiv = q.size() != 0 && !redirect_valid;
      check("req_valid", mem_req_valid, erv);
      if (erv) check("req_addr", mem_req_addr, fpc);
      check("inst_valid", inst_valid, eiv);
      if (eiv) begin
        check("inst_pc", inst_pc, q[0].pc);
        check("inst_data", inst_data, q[0].inst);
      end
      if (mem_rsp_valid) void'(mq.pop_front());
      if (mem_req_valid && mem_req_ready) mq.push_back('{mem_req_addr, cyc + int'($urandom_range(1, 3))});
      if (redirect_valid) begin
        q.delete();
        fpc = {redirect_pc[31:2], 2'b00};
        if (inflight && mem_rsp_valid) begin
          inflight = 0;
          drop = 0;
        end else if (inflight) drop = 1;
      end else begin
        if (eiv && inst_ready) void'(q.pop_front());
        if (inflight && mem_rsp_valid) begin
          if (!drop) q.push_back('{req_pc, mem_rsp_data});
          inflight = 0;
          drop = 0;
        end
        if (erv && mem_req_ready) begin
          inflight = 1;
          req_pc = fpc;
          fpc = fpc + 32'd4;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
